dmi_arb_buf: RTL and testbench
==============================

# dmi_arb_buf

Single-clock, parametrised DMI arbiter and response router that lets `NumCh` debug transports (JTAG DTM, a secondary DTM, a TL-UL bridge) share one Debug Module DMI port. It round-robin arbitrates requests into a registered output stage. An in-order tag FIFO records the issuing channel of up to `MaxOutstanding` requests, and each DM response goes back to the channel that issued it. It sits on the core clock between the transport-side clock-domain crossings and `dm_top`.

## Interface
- `NumCh`, default 2: number of requesting channels, legal range 2..8.
- `MaxOutstanding`, default 4: tag FIFO depth, which is the maximum number of in-flight DM requests. Legal range 1..16.
- `clk_i` in 1: core clock; everything is on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high. It clears all state.
- `ch_req_i` in NumCh x $bits(dm::dmi_req_t): per-channel request payload (addr/data/op).
- `ch_req_valid_i` in NumCh: per-channel request valid.
- `ch_req_ready_o` out NumCh: per-channel request accept, one-hot or zero.
- `ch_resp_o` out NumCh x $bits(dm::dmi_resp_t): per-channel response payload.
- `ch_resp_valid_o` out NumCh: per-channel response valid.
- `ch_resp_ready_i` in NumCh: per-channel response ready.
- `dm_req_o` out $bits(dm::dmi_req_t): request to the DM.
- `dm_req_valid_o` out 1: request valid to the DM.
- `dm_req_ready_i` in 1: DM request ready.
- `dm_resp_i` in $bits(dm::dmi_resp_t): DM response payload.
- `dm_resp_valid_i` in 1: DM response valid.
- `dm_resp_ready_o` out 1: response accept.
- `outstanding_o` out $clog2(MaxOutstanding+1): current tag FIFO occupancy.

## Operation
- **Request register (RQ):** one entry holding a payload and a valid bit. RQ is free when it is empty, or when it is full and `dm_req_ready_i`=1 in the same cycle (pass-through refill).
- **Grant condition:** RQ free AND `outstanding_o` < `MaxOutstanding`. Occupancy is evaluated before any same-cycle pop, so a full FIFO blocks the grant even if a pop happens that cycle.
- **Arbiter:** round-robin over `ch_req_valid_i`.
  - Search starts at `last+1` mod `NumCh`.
  - `last` resets to `NumCh-1`, so channel 0 wins first.
  - `last` updates only on a grant.
- **On grant g:**
  - `ch_req_ready_o[g]`=1 that cycle.
  - RQ loads `ch_req_i[g]`.
  - Channel index g is pushed into the tag FIFO.
- **Request stability:** a channel with valid high and no grant keeps its request; the block never drops requests.
- **Response path:**
  - Each channel has a 1-entry response register (RR[c]).
  - `dm_resp_ready_o` = FIFO not empty AND (RR[head] empty OR `ch_resp_ready_i[head]`).
  - On a DM response handshake: pop the FIFO and load RR[head] with `dm_resp_i`.
  - `ch_resp_valid_o[c]` clears on `ch_resp_ready_i[c]` unless it is reloaded in the same cycle.
- **Empty FIFO:** `dm_resp_ready_o`=0. A response arriving with no outstanding request is never accepted.
- **Same-cycle push and pop:** both are allowed when the FIFO is neither full (push) nor empty (pop). Occupancy is unchanged and pointers wrap modulo `MaxOutstanding`.
- **Ordering:**
  - Responses are assumed to return from the DM in request order.
  - Per-channel order is preserved.
  - Cross-channel interleaving follows grant order.
- **Reset mid-operation:** in-flight requests and responses are discarded. Transports must re-issue after reset deasserts.

## Timing
- **Reset values:**
  - `dm_req_valid_o`=0, `ch_resp_valid_o`=0, `outstanding_o`=0.
  - `dm_req_o`, `ch_resp_o`, and the RR payloads are all zero.
  - `ch_req_ready_o` and `dm_resp_ready_o` are forced to 0 while `rst_i`=1.
- **Request latency:** a channel handshake in cycle N gives `dm_req_valid_o`=1 in cycle N+1.
- **Response latency:** a DM handshake in cycle N gives `ch_resp_valid_o[c]`=1 in cycle N+1.
- **Request throughput:** 1 request/cycle sustained while `dm_req_ready_i`=1 and the FIFO is not full.
- **Response throughput:** 1 response/cycle sustained while the consuming channel is ready.
- **Combinational paths:**
  - `ch_req_valid_i`/`dm_req_ready_i` → `ch_req_ready_o`.
  - `ch_resp_ready_i` → `dm_resp_ready_o`.
  - There is no combinational path from a payload input to any output.
- **Valid/ready rule:** valid must not depend on ready on any port. Payloads are held stable while valid=1 and ready=0.

## Test plan
- **Basic round trip:** reset, then ch0 sends op=read addr=0x11. Required: `dm_req_valid_o` rises 1 cycle later with addr 0x11. A DM response data=0xCAFE0001 resp=0 appears on ch0 only, 1 cycle after the DM handshake, and `outstanding_o` returns to 0.
- **Fairness:** NumCh=2, both channels hold valid continuously with `dm_req_ready_i`=1. Required: grants alternate ch0, ch1, ch0, ch1, and neither channel waits more than 1 grant.
- **Full FIFO:** MaxOutstanding=4 with no DM responses. Required: exactly 4 grants, then every `ch_req_ready_o`=0 and `outstanding_o`=4. One DM response lets exactly one further grant, no earlier than the cycle after the pop.
- **Routing with backpressure:** issue ch1, ch0, ch1 with `ch_resp_ready_i[1]`=0. Required:
  - The first response parks in RR[1].
  - The second response lands on ch0.
  - The third response stalls (`dm_resp_ready_o`=0) until ch1 drains.
  - Payloads are uncorrupted.
- **Pointer wrap:** 20 back-to-back requests with same-cycle push/pop. Required: `outstanding_o` stays constant and responses route correctly across the wrap.
- **Async reset:** assert `rst_i` mid-flight with 3 outstanding. Required: all valids are 0 and `outstanding_o`=0 immediately without a clock edge, and a spurious `dm_resp_valid_i` is not accepted.

Source files
------------

// File: rtl/dmi_arb_buf.sv
// DMI arbiter and response router: round-robin grants N transports onto one DM port,
// tracks the issuing channel of each in-flight request and steers DM responses back.
package dm;
  localparam logic [1:0] DTM_NOP   = 2'd0;
  localparam logic [1:0] DTM_READ  = 2'd1;
  localparam logic [1:0] DTM_WRITE = 2'd2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_arb_buf #(
  parameter int unsigned NumCh          = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  dm::dmi_req_t  [NumCh-1:0]            ch_req_i,
  input  logic          [NumCh-1:0]            ch_req_valid_i,
  output logic          [NumCh-1:0]            ch_req_ready_o,
  output dm::dmi_resp_t [NumCh-1:0]            ch_resp_o,
  output logic          [NumCh-1:0]            ch_resp_valid_o,
  input  logic          [NumCh-1:0]            ch_resp_ready_i,
  output dm::dmi_req_t                         dm_req_o,
  output logic                                 dm_req_valid_o,
  input  logic                                 dm_req_ready_i,
  input  dm::dmi_resp_t                        dm_resp_i,
  input  logic                                 dm_resp_valid_i,
  output logic                                 dm_resp_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

  localparam int unsigned ChW  = $clog2(NumCh);
  localparam int unsigned ChW1 = ChW + 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(MaxOutstanding - 1);
  localparam logic [ChW1-1:0] NumChW   = ChW1'(NumCh);
  localparam logic [ChW-1:0]  LastInit = ChW'(NumCh - 1);

  // Request register
  dm::dmi_req_t rq_q, rq_d;
  logic         rq_valid_q, rq_valid_d;

  // Arbiter state
  logic [ChW-1:0]  last_q, last_d;
  logic [ChW-1:0]  arb_idx;
  logic            arb_found;
  logic [ChW1-1:0] cand;

  // Tag FIFO
  logic [ChW-1:0]  tag_q [MaxOutstanding];
  logic [ChW-1:0]  tag_d [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Per-channel response registers
  dm::dmi_resp_t [NumCh-1:0] rr_q, rr_d;
  logic          [NumCh-1:0] rr_valid_q, rr_valid_d;

  logic           rq_free;
  logic           fifo_full;
  logic           fifo_empty;
  logic           grant;
  logic           pop;
  logic [ChW-1:0] head;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NumCh; off++) begin
      cand = {1'b0, last_q} + ChW1'(off);
      if (cand >= NumChW) begin
        cand = cand - NumChW;
      end
      if (!arb_found && ch_req_valid_i[cand[ChW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[ChW-1:0];
      end
    end
  end

  // Occupancy is taken before any same-cycle pop, so a full FIFO always blocks
  assign rq_free    = !rq_valid_q || dm_req_ready_i;
  assign fifo_full  = (cnt_q == MaxCnt);
  assign fifo_empty = (cnt_q == '0);
  assign grant      = !rst_i && rq_free && !fifo_full && arb_found;
  assign head       = tag_q[rptr_q];

  assign dm_resp_ready_o = !rst_i && !fifo_empty &&
                           (!rr_valid_q[head] || ch_resp_ready_i[head]);
  assign pop = dm_resp_valid_i && dm_resp_ready_o;

  always_comb begin
    ch_req_ready_o = '0;
    if (grant) begin
      ch_req_ready_o[arb_idx] = 1'b1;
    end
  end

  // Request register load / drain
  always_comb begin
    rq_d       = rq_q;
    rq_valid_d = rq_valid_q;
    last_d     = last_q;
    if (grant) begin
      rq_d       = ch_req_i[arb_idx];
      rq_valid_d = 1'b1;
      last_d     = arb_idx;
    end else if (dm_req_ready_i) begin
      rq_valid_d = 1'b0;
    end
  end

  // Tag FIFO push/pop with modulo-depth pointers
  always_comb begin
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (grant) begin
      tag_d[wptr_q] = arb_idx;
      wptr_d        = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    end
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response steering: a reload wins over a same-cycle drain
  always_comb begin
    rr_d       = rr_q;
    rr_valid_d = rr_valid_q;
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (pop && (head == ChW'(c))) begin
        rr_d[c]       = dm_resp_i;
        rr_valid_d[c] = 1'b1;
      end else if (ch_resp_ready_i[c]) begin
        rr_valid_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rq_q       <= '0;
      rq_valid_q <= 1'b0;
      last_q     <= LastInit;
      tag_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      rr_valid_q <= '0;
    end else begin
      rq_q       <= rq_d;
      rq_valid_q <= rq_valid_d;
      last_q     <= last_d;
      tag_q      <= tag_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      rr_valid_q <= rr_valid_d;
    end
  end

  assign dm_req_o        = rq_q;
  assign dm_req_valid_o  = rq_valid_q;
  assign ch_resp_o       = rr_q;
  assign ch_resp_valid_o = rr_valid_q;
  assign outstanding_o   = cnt_q;

endmodule

// File: tb/tb_dmi_arb_buf.sv
// Directed bench for dmi_arb_buf: round trip, fairness, full FIFO, routing under
// backpressure, pointer wrap and asynchronous reset.
module tb_dmi_arb_buf;
  localparam int unsigned NumCh  = 2;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned CntW   = $clog2(MaxOut + 1);

  logic                       clk;
  logic                       rst;
  dm::dmi_req_t  [NumCh-1:0]  ch_req;
  logic          [NumCh-1:0]  ch_req_valid;
  logic          [NumCh-1:0]  ch_req_ready;
  dm::dmi_resp_t [NumCh-1:0]  ch_resp;
  logic          [NumCh-1:0]  ch_resp_valid;
  logic          [NumCh-1:0]  ch_resp_ready;
  dm::dmi_req_t               dm_req;
  logic                       dm_req_valid;
  logic                       dm_req_ready;
  dm::dmi_resp_t              dm_resp;
  logic                       dm_resp_valid;
  logic                       dm_resp_ready;
  logic [CntW-1:0]            outstanding;

  int errors = 0;
  int checks = 0;

  dmi_arb_buf #(.NumCh(NumCh), .MaxOutstanding(MaxOut)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ch_req_i        (ch_req),
    .ch_req_valid_i  (ch_req_valid),
    .ch_req_ready_o  (ch_req_ready),
    .ch_resp_o       (ch_resp),
    .ch_resp_valid_o (ch_resp_valid),
    .ch_resp_ready_i (ch_resp_ready),
    .dm_req_o        (dm_req),
    .dm_req_valid_o  (dm_req_valid),
    .dm_req_ready_i  (dm_req_ready),
    .dm_resp_i       (dm_resp),
    .dm_resp_valid_i (dm_resp_valid),
    .dm_resp_ready_o (dm_resp_ready),
    .outstanding_o   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dm::dmi_req_t mk_req(input logic [6:0] a, input logic [1:0] op,
                                          input logic [31:0] d);
    dm::dmi_req_t r;
    r.addr = a;
    r.op   = op;
    r.data = d;
    return r;
  endfunction

  function automatic dm::dmi_resp_t mk_resp(input logic [31:0] d, input logic [1:0] rs);
    dm::dmi_resp_t r;
    r.data = d;
    r.resp = rs;
    return r;
  endfunction

  initial begin
    logic [1:0] exp_v;
    logic       ch;

    rst           = 1'b1;
    ch_req        = '0;
    ch_req_valid  = 2'b11;
    ch_resp_ready = 2'b00;
    dm_req_ready  = 1'b0;
    dm_resp       = '0;
    dm_resp_valid = 1'b1;
    #1;
    check("rst_dm_req_valid", 64'(dm_req_valid), 64'd0);
    check("rst_dm_req", 64'(dm_req), 64'd0);
    check("rst_ch_resp_valid", 64'(ch_resp_valid), 64'd0);
    check("rst_ch_resp", 64'(ch_resp), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_ch_req_ready", 64'(ch_req_ready), 64'd0);
    check("rst_dm_resp_ready", 64'(dm_resp_ready), 64'd0);
    tick();
    ch_req_valid  = 2'b00;
    dm_resp_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Basic round trip on ch0
    ch_req[0]     = mk_req(7'h11, dm::DTM_READ, 32'h0);
    ch_req_valid  = 2'b01;
    dm_req_ready  = 1'b1;
    ch_resp_ready = 2'b11;
    #1;
    check("rt_grant", 64'(ch_req_ready), 64'h1);
    tick();
    ch_req_valid = 2'b00;
    check("rt_dm_req_valid", 64'(dm_req_valid), 64'd1);
    check("rt_dm_req", 64'(dm_req), 64'(mk_req(7'h11, dm::DTM_READ, 32'h0)));
    check("rt_outstanding1", 64'(outstanding), 64'd1);
    dm_resp       = mk_resp(32'hCAFE0001, 2'd0);
    dm_resp_valid = 1'b1;
    #1;
    check("rt_dm_resp_ready", 64'(dm_resp_ready), 64'd1);
    tick();
    dm_resp_valid = 1'b0;
    check("rt_resp_valid", 64'(ch_resp_valid), 64'h1);
    check("rt_resp", 64'(ch_resp[0]), 64'(mk_resp(32'hCAFE0001, 2'd0)));
    check("rt_outstanding0", 64'(outstanding), 64'd0);
    check("rt_req_drained", 64'(dm_req_valid), 64'd0);
    tick();
    check("rt_resp_cleared", 64'(ch_resp_valid), 64'd0);

    // Fairness and full FIFO: last grant was ch0, so ch1 goes first
    ch_req[0]    = mk_req(7'h20, dm::DTM_WRITE, 32'hA0A0A0A0);
    ch_req[1]    = mk_req(7'h21, dm::DTM_READ,  32'hB1B1B1B1);
    ch_req_valid = 2'b11;
    #1;
    check("fair_g0", 64'(ch_req_ready), 64'h2);
    tick();
    check("fair_g1", 64'(ch_req_ready), 64'h1);
    check("fair_req1", 64'(dm_req), 64'(mk_req(7'h21, dm::DTM_READ, 32'hB1B1B1B1)));
    tick();
    check("fair_g2", 64'(ch_req_ready), 64'h2);
    check("fair_req0", 64'(dm_req), 64'(mk_req(7'h20, dm::DTM_WRITE, 32'hA0A0A0A0)));
    tick();
    check("fair_g3", 64'(ch_req_ready), 64'h1);
    tick();
    check("full_no_grant", 64'(ch_req_ready), 64'h0);
    check("full_outstanding", 64'(outstanding), 64'd4);
    dm_resp       = mk_resp(32'h0000F001, 2'd0);
    dm_resp_valid = 1'b1;
    #1;
    check("full_pop_ready", 64'(dm_resp_ready), 64'd1);
    check("full_no_grant_on_pop", 64'(ch_req_ready), 64'h0);
    tick();
    dm_resp_valid = 1'b0;
    check("full_after_pop_cnt", 64'(outstanding), 64'd3);
    check("full_resp_ch1", 64'(ch_resp_valid), 64'h2);
    check("full_resp_data", 64'(ch_resp[1]), 64'(mk_resp(32'h0000F001, 2'd0)));
    check("full_one_more_grant", 64'(ch_req_ready), 64'h2);
    tick();
    ch_req_valid = 2'b00;
    check("full_again_cnt", 64'(outstanding), 64'd4);
    check("full_again_block", 64'(ch_req_ready), 64'h0);

    // Drain: queued tags are ch0, ch1, ch0, ch1
    for (int i = 0; i < 4; i++) begin
      dm_resp       = mk_resp(32'h1000 + 32'(i), 2'd0);
      dm_resp_valid = 1'b1;
      tick();
      exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
      ch    = 1'(i % 2);
      check("drain_route", 64'(ch_resp_valid), 64'(exp_v));
      check("drain_data", 64'(ch_resp[ch].data), 64'h1000 + 64'(i));
    end
    dm_resp_valid = 1'b0;
    check("drain_empty", 64'(outstanding), 64'd0);

    // Routing with backpressure: issue ch1, ch0, ch1
    ch_req_valid = 2'b10;
    #1;
    check("bp_g_ch1a", 64'(ch_req_ready), 64'h2);
    tick();
    ch_req_valid = 2'b01;
    #1;
    check("bp_g_ch0", 64'(ch_req_ready), 64'h1);
    tick();
    ch_req_valid = 2'b10;
    #1;
    check("bp_g_ch1b", 64'(ch_req_ready), 64'h2);
    tick();
    ch_req_valid  = 2'b00;
    ch_resp_ready = 2'b01;
    check("bp_outstanding", 64'(outstanding), 64'd3);
    dm_resp       = mk_resp(32'hAAAA0001, 2'd0);
    dm_resp_valid = 1'b1;
    #1;
    check("bp_ready_a", 64'(dm_resp_ready), 64'd1);
    tick();
    check("bp_park_ch1", 64'(ch_resp_valid), 64'h2);
    check("bp_park_data", 64'(ch_resp[1]), 64'(mk_resp(32'hAAAA0001, 2'd0)));
    dm_resp = mk_resp(32'hBBBB0000, 2'd2);
    #1;
    check("bp_ready_b", 64'(dm_resp_ready), 64'd1);
    tick();
    check("bp_both_valid", 64'(ch_resp_valid), 64'h3);
    check("bp_ch0_data", 64'(ch_resp[0]), 64'(mk_resp(32'hBBBB0000, 2'd2)));
    dm_resp = mk_resp(32'hCCCC0001, 2'd0);
    #1;
    check("bp_stall", 64'(dm_resp_ready), 64'd0);
    tick();
    check("bp_stall_valid", 64'(ch_resp_valid), 64'h2);
    check("bp_stall_keep", 64'(ch_resp[1]), 64'(mk_resp(32'hAAAA0001, 2'd0)));
    check("bp_stall_cnt", 64'(outstanding), 64'd1);
    ch_resp_ready = 2'b11;
    #1;
    check("bp_release", 64'(dm_resp_ready), 64'd1);
    tick();
    dm_resp_valid = 1'b0;
    check("bp_reload_valid", 64'(ch_resp_valid), 64'h2);
    check("bp_reload_data", 64'(ch_resp[1]), 64'(mk_resp(32'hCCCC0001, 2'd0)));
    check("bp_empty", 64'(outstanding), 64'd0);
    tick();
    check("bp_drained", 64'(ch_resp_valid), 64'h0);

    // Pointer wrap: one in flight, then push and pop every cycle
    ch_req_valid = 2'b11;
    tick();
    check("wrap_prime", 64'(outstanding), 64'd1);
    for (int i = 0; i < 20; i++) begin
      dm_resp       = mk_resp(32'h5000 + 32'(i), 2'd0);
      dm_resp_valid = 1'b1;
      tick();
      exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
      ch    = 1'(i % 2);
      check("wrap_cnt", 64'(outstanding), 64'd1);
      check("wrap_route", 64'(ch_resp_valid), 64'(exp_v));
      check("wrap_data", 64'(ch_resp[ch].data), 64'h5000 + 64'(i));
    end
    ch_req_valid = 2'b00;
    dm_resp      = mk_resp(32'h5014, 2'd0);
    tick();
    dm_resp_valid = 1'b0;
    check("wrap_last_route", 64'(ch_resp_valid), 64'h1);
    check("wrap_last_data", 64'(ch_resp[0].data), 64'h5014);
    check("wrap_empty", 64'(outstanding), 64'd0);
    tick();
    check("wrap_drained", 64'(ch_resp_valid), 64'h0);

    // Async reset with 3 outstanding and a parked response
    ch_req_valid = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    ch_req_valid  = 2'b00;
    dm_req_ready  = 1'b0;
    ch_resp_ready = 2'b00;
    dm_resp       = mk_resp(32'h77770000, 2'd0);
    dm_resp_valid = 1'b1;
    tick();
    dm_resp_valid = 1'b0;
    check("ar_pre_cnt", 64'(outstanding), 64'd3);
    check("ar_pre_resp", 64'(ch_resp_valid), 64'h1);
    check("ar_pre_req", 64'(dm_req_valid), 64'd1);
    #2;
    rst           = 1'b1;
    ch_req_valid  = 2'b01;
    dm_resp_valid = 1'b1;
    #1;
    check("ar_req_valid", 64'(dm_req_valid), 64'd0);
    check("ar_resp_valid", 64'(ch_resp_valid), 64'h0);
    check("ar_cnt", 64'(outstanding), 64'd0);
    check("ar_resp_ready", 64'(dm_resp_ready), 64'd0);
    check("ar_req_ready", 64'(ch_req_ready), 64'h0);
    check("ar_payload", 64'(ch_resp), 64'd0);
    tick();
    check("ar_hold_cnt", 64'(outstanding), 64'd0);
    rst          = 1'b0;
    ch_req_valid = 2'b00;
    #1;
    check("ar_spurious_ready", 64'(dm_resp_ready), 64'd0);
    tick();
    dm_resp_valid = 1'b0;
    check("ar_spurious_cnt", 64'(outstanding), 64'd0);
    check("ar_spurious_resp", 64'(ch_resp_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
